// File: rtl/key_evt_pkg.sv
// Shared state encoding, default timing parameters and width helpers for the key event decoder.
package key_evt_pkg;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_DCLICK_MS = 300;
  localparam int DEF_REPEAT_MS = 200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// 1 ms prescaler: tick is high for the last clk of every TICK_DIV-cycle window; clr restarts the window.
// No backpressure; tick is a decode of the registered count, so it never depends on clr combinationally.
module ms_tick
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int                DIV_W = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short/long/double-click/auto-repeat pulses.
// Pulses are registered, one clk after the deciding edge; no backpressure, inputs are strobes.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int DCLICK_MS = DEF_DCLICK_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic busy
);

  localparam int               MS_W        = cnt_width(max3(LONG_MS, DCLICK_MS, REPEAT_MS));
  localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0] DCLICK_LAST = MS_W'(DCLICK_MS - 1);
  localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'(REPEAT_MS - 1);

  state_t          r_state;
  state_t          w_next;
  logic [MS_W-1:0] r_ms;
  logic [MS_W-1:0] w_lim;
  logic            w_tick;
  logic            w_clr;
  logic            w_restart;
  logic            w_press;
  logic            w_release;
  logic            w_expire;
  logic            w_short;
  logic            w_long;
  logic            w_dbl;
  logic            w_rep;
  logic            r_short;
  logic            r_long;
  logic            r_dbl;
  logic            r_rep;
  logic            r_busy;

  assign w_press   = key_flag & ~key_state;
  assign w_release = key_flag &  key_state;
  assign w_expire  = w_tick && (r_ms == w_lim);

  // Timer restarts on any state change; IDLE and PRESS2 have no timeout so it is held cleared there.
  assign w_clr = (w_next != r_state) || w_restart ||
                 (r_state == ST_IDLE) || (r_state == ST_PRESS2);

  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_lim = '0;
    case (r_state)
      ST_PRESS1: w_lim = LONG_LAST;
      ST_WAIT2:  w_lim = DCLICK_LAST;
      ST_LONG:   w_lim = REPEAT_LAST;
      default:   w_lim = '0;
    endcase
  end

  // Events are tested before expiry in every state so a coincident edge suppresses the timeout pulse.
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_short   = 1'b0;
    w_long    = 1'b0;
    w_dbl     = 1'b0;
    w_rep     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_press) w_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_release) begin
          w_next = ST_WAIT2;
        end else if (w_expire) begin
          w_next = ST_LONG;
          w_long = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (w_press) begin
          w_next = ST_PRESS2;
        end else if (w_expire) begin
          w_next  = ST_IDLE;
          w_short = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_release) begin
          w_next = ST_IDLE;
          w_dbl  = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_release) begin
          w_next = ST_IDLE;
        end else if (w_expire) begin
          w_rep     = 1'b1;
          w_restart = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ms    <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_ms <= '0;
      end else if (w_tick) begin
        r_ms <= r_ms + 1'b1;
      end
      r_short <= w_short;
      r_long  <= w_long;
      r_dbl   <= w_dbl;
      r_rep   <= w_rep;
      r_busy  <= (w_next != ST_IDLE);
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_click = r_dbl;
  assign repeat_pulse = r_rep;
  assign busy         = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed scenarios plus random key edges, checked every cycle against a deadline-based reference model.
module tb_key_event_decoder;

  localparam int TD  = 10;
  localparam int LMS = 20;
  localparam int DMS = 6;
  localparam int RMS = 4;

  localparam int M_IDLE  = 0;
  localparam int M_HELD1 = 1;
  localparam int M_GAP   = 2;
  localparam int M_HELD2 = 3;
  localparam int M_LONG  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic short_press, long_press, double_click, repeat_pulse, busy;

  key_event_decoder #(
    .TICK_DIV (TD),
    .LONG_MS  (LMS),
    .DCLICK_MS(DMS),
    .REPEAT_MS(RMS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;

  int   m_mode = M_IDLE;
  int   m_start = 0;
  logic e_short, e_long, e_dbl, e_rep;

  int obs_short = 0, obs_long = 0, obs_dbl = 0, obs_rep = 0;
  int last_short = -1, last_long = -1, last_dbl = -1;
  int rep_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each timed mode has a deadline of (ms * TD) edges after the edge that entered it.
  task automatic model_step(input logic f, input logic s);
    bit press;
    bit rel;
    int el;
    press = f && !s;
    rel   = f && s;
    el    = n - m_start;
    e_short = 1'b0; e_long = 1'b0; e_dbl = 1'b0; e_rep = 1'b0;
    case (m_mode)
      M_IDLE:  if (press) begin m_mode = M_HELD1; m_start = n; end
      M_HELD1: if (rel) begin m_mode = M_GAP; m_start = n; end
               else if (el == LMS * TD) begin e_long = 1'b1; m_mode = M_LONG; m_start = n; end
      M_GAP:   if (press) begin m_mode = M_HELD2; m_start = n; end
               else if (el == DMS * TD) begin e_short = 1'b1; m_mode = M_IDLE; end
      M_HELD2: if (rel) begin e_dbl = 1'b1; m_mode = M_IDLE; end
      M_LONG:  if (rel) m_mode = M_IDLE;
               else if (el == RMS * TD) begin e_rep = 1'b1; m_start = n; end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cyc(input logic f, input logic s);
    key_flag  = f;
    key_state = s;
    @(posedge clk);
    n++;
    model_step(f, s);
    #1;
    chk("short_press", short_press, e_short);
    chk("long_press", long_press, e_long);
    chk("double_click", double_click, e_dbl);
    chk("repeat_pulse", repeat_pulse, e_rep);
    chk("busy", busy, (m_mode != M_IDLE));
    chk("pulse_onehot", ($countones({short_press, long_press, double_click, repeat_pulse}) <= 1), 1);
    if (short_press === 1'b1)  begin obs_short++; last_short = n; end
    if (long_press === 1'b1)   begin obs_long++;  last_long  = n; end
    if (double_click === 1'b1) begin obs_dbl++;   last_dbl   = n; end
    if (repeat_pulse === 1'b1) begin obs_rep++;   rep_hist.push_back(n); end
    key_flag = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_short"}, short_press, 0);
    chk({tag, "_long"}, long_press, 0);
    chk({tag, "_dbl"}, double_click, 0);
    chk({tag, "_rep"}, repeat_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    m_mode = M_IDLE;
    rst_n  = 1'b1;
  endtask

  initial begin
    int p, r, s0, l0, d0, rp0;
    bit ks;
    int gap;

    #1;
    chk_all_zero("reset_state");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Release while idle is ignored.
    s0 = obs_short; d0 = obs_dbl;
    cyc(1'b1, 1'b1);
    chk("r037_idle_rel_busy", busy, 0);
    idle(100);
    chk("r037_idle_rel_pulses", obs_short + obs_dbl + obs_long + obs_rep, 0);

    // Single short click.
    s0 = obs_short;
    cyc(1'b1, 1'b0); p = n;
    idle(49);
    cyc(1'b1, 1'b1); r = n;
    idle(70);
    chk("r032_short_cnt", obs_short - s0, 1);
    chk("r032_short_lat", last_short - r, 60);
    chk("r032_busy_end", busy, 0);

    // Second press while held is ignored; click still resolves as short.
    s0 = obs_short; l0 = obs_long;
    cyc(1'b1, 1'b0);
    idle(9);
    cyc(1'b1, 1'b0);
    idle(9);
    chk("r037_press1_busy", busy, 1);
    cyc(1'b1, 1'b1); r = n;
    idle(65);
    chk("r037_press1_short_cnt", obs_short - s0, 1);
    chk("r037_press1_short_lat", last_short - r, 60);
    chk("r037_press1_no_long", obs_long - l0, 0);

    // Double click.
    s0 = obs_short; d0 = obs_dbl;
    cyc(1'b1, 1'b0); p = n;
    idle(49);
    cyc(1'b1, 1'b1);
    idle(29);
    cyc(1'b1, 1'b0);
    idle(39);
    cyc(1'b1, 1'b1); r = n;
    idle(80);
    chk("r033_dbl_cnt", obs_dbl - d0, 1);
    chk("r033_dbl_edge", last_dbl - r, 0);
    chk("r033_no_short", obs_short - s0, 0);

    // Long press with auto-repeat.
    s0 = obs_short; l0 = obs_long; rp0 = obs_rep;
    rep_hist.delete();
    cyc(1'b1, 1'b0); p = n;
    idle(299);
    cyc(1'b1, 1'b1);
    idle(80);
    chk("r034_long_cnt", obs_long - l0, 1);
    chk("r034_long_lat", last_long - p, 200);
    chk("r034_rep_cnt", obs_rep - rp0, 2);
    chk("r034_rep1_lat", (rep_hist.size() > 0) ? rep_hist[0] - p : -1, 240);
    chk("r034_rep2_lat", (rep_hist.size() > 1) ? rep_hist[1] - p : -1, 280);
    chk("r034_no_short", obs_short - s0, 0);
    chk("r034_busy_end", busy, 0);

    // Press coincident with the double-click window expiry.
    s0 = obs_short; d0 = obs_dbl;
    cyc(1'b1, 1'b0);
    idle(19);
    cyc(1'b1, 1'b1); r = n;
    idle(59);
    cyc(1'b1, 1'b0);
    chk("r035_no_short", obs_short - s0, 0);
    chk("r035_busy", busy, 1);
    idle(5);
    cyc(1'b1, 1'b1);
    chk("r035_dbl_cnt", obs_dbl - d0, 1);
    idle(80);
    chk("r035_no_short_late", obs_short - s0, 0);

    // Reset during the double-click window aborts the pending short press.
    s0 = obs_short; l0 = obs_long; d0 = obs_dbl; rp0 = obs_rep;
    cyc(1'b1, 1'b0);
    idle(19);
    cyc(1'b1, 1'b1);
    idle(20);
    pulse_reset();
    idle(100);
    chk("r036_no_pulses", (obs_short - s0) + (obs_long - l0) + (obs_dbl - d0) + (obs_rep - rp0), 0);
    chk("r036_busy", busy, 0);

    // After reset a leading release is ignored.
    cyc(1'b1, 1'b1);
    idle(80);
    chk("r029_busy", busy, 0);
    chk("r029_no_short", obs_short - s0, 0);

    // Random key activity, mostly alternating edges with some out-of-order ones.
    ks = 1'b1;
    repeat (60) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 320) : $urandom_range(1, 80);
      idle(gap);
      if ($urandom_range(0, 9) < 8) ks = !ks;
      cyc(1'b1, ks);
    end
    idle(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per 1 ms tick (50 MHz clk).
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning hold time in ms that qualifies a long press.
REQ-003 SHALL have parameter DCLICK_MS, default 300, meaning the maximum release-to-second-press gap in ms.
REQ-004 SHALL have parameter REPEAT_MS, default 200, meaning the auto-repeat period in ms after a long press.
REQ-005 SHALL have port clk, input, 1 bit, meaning the system clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning the reset, asynchronous, active-low.
REQ-007 SHALL have port key_flag, input, 1 bit, meaning a one-cycle debounced-edge strobe from the key filter.
REQ-008 SHALL have port key_state, input, 1 bit, meaning the debounced level (0 = pressed, 1 = released), sampled only when key_flag=1.
REQ-009 SHALL have port short_press, output, 1 bit, meaning a one-cycle pulse for a single short click.
REQ-010 SHALL have port long_press, output, 1 bit, meaning a one-cycle pulse when the hold reaches LONG_MS.
REQ-011 SHALL have port double_click, output, 1 bit, meaning a one-cycle pulse on release of the second click.
REQ-012 SHALL have port repeat_pulse, output, 1 bit, meaning a one-cycle pulse every REPEAT_MS while held after a long press.
REQ-013 SHALL have port busy, output, 1 bit, meaning high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PRESS1, WAIT2, PRESS2 and LONG.
REQ-015 SHALL define a press event as key_flag=1 with key_state=0, and a release event as key_flag=1 with key_state=1.
REQ-016 SHALL use a ms timer (prescaler plus ms counter) that clears on every state transition, so each interval is measured exactly from the transition edge.
REQ-017 IDLE: on a press event SHALL go to PRESS1; release events SHALL be ignored.
REQ-018 PRESS1: on a release event SHALL go to WAIT2; when the timer reaches LONG_MS SHALL pulse long_press and go to LONG.
REQ-019 WAIT2: on a press event SHALL go to PRESS2; when the timer reaches DCLICK_MS SHALL pulse short_press and go to IDLE.
REQ-020 PRESS2: on a release event SHALL pulse double_click and go to IDLE, whatever the hold duration.
REQ-021 LONG: SHALL pulse repeat_pulse each time the timer reaches REPEAT_MS, then restart the timer; on a release event SHALL go to IDLE with no further pulse.
REQ-022 Out-of-order events (a press in PRESS1, PRESS2 or LONG; a release in WAIT2) SHALL be ignored.
REQ-023 If an event and a timer expiry occur in the same cycle, the event SHALL win and the expiry pulse SHALL be suppressed.
REQ-024 All outputs SHALL be registered; each pulse SHALL be high for exactly one cycle, one cycle after the deciding edge.
REQ-025 At most one of the four pulse outputs SHALL be high in any cycle.
REQ-026 Counter widths SHALL be ceil(log2) of the largest parameter value; the counters SHALL never wrap, because they clear at their limit.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE, all counters 0 and all outputs 0.
REQ-028 Reset asserted mid-operation SHALL abort the sequence; no pending pulse SHALL be emitted after reset release.
REQ-029 After reset release, the first accepted event SHALL be a press; a release seen first SHALL be ignored.

Structure
REQ-030 A shared package key_evt_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-031 The prescaler SHALL be the sub-module ms_tick (inputs clk, rst_n, clr; output tick), instantiated once.

Verification (sim params: TICK_DIV=10, LONG_MS=20, DCLICK_MS=6, REPEAT_MS=4)
REQ-032 Press, release 50 cycles later, no further events -> a single short_press pulse 60 cycles after the release flag, then busy=0.
REQ-033 Press, release at +50, press at +80, release at +120 -> a single double_click pulse one cycle after the last release; no short_press.
REQ-034 Press held for 300 cycles -> long_press at +200, repeat_pulse at +240 and +280, release -> IDLE with no short_press.
REQ-035 In WAIT2, a press flag coincident with the 60-cycle expiry -> no short_press; the FSM enters PRESS2.
REQ-036 Reset pulsed during WAIT2, then idle for 100 cycles -> all outputs stay 0 and busy=0.
REQ-037 A release flag in IDLE, or a second press flag in PRESS1 -> no state change and no pulses.
